// File: rtl/vecseq_pkg.sv
// Shared types and constants for vector_sequencer.
// VECTOR_SEQUENCER_COMPARE_EN adds the expected-value field to the FIFO entry.
package vecseq_pkg;

    localparam int unsigned IDX_W     = 16;
    localparam int unsigned DEF_IN_W  = 20;
    localparam int unsigned DEF_OUT_W = 10;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        CAPTURE,
        EMIT
    } state_t;

    typedef struct packed {
        logic                 last;
        logic [DEF_IN_W-1:0]  data;
`ifdef VECTOR_SEQUENCER_COMPARE_EN
        logic [DEF_OUT_W-1:0] exp;
`endif
    } vecseq_entry_t;

endpackage

// File: rtl/vector_sequencer_if.sv
// Stimulus-in / result-out stream bundle for vector_sequencer.
// VECTOR_SEQUENCER_COMPARE_EN adds exp_data and res_mismatch.
interface vector_sequencer_if #(
    parameter int unsigned IN_W  = 20,
    parameter int unsigned OUT_W = 10
);
    import vecseq_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             in_last;
    logic             res_valid;
    logic             res_ready;
    logic [OUT_W-1:0] res_data;
    logic [IDX_W-1:0] res_idx;
`ifdef VECTOR_SEQUENCER_COMPARE_EN
    logic [OUT_W-1:0] exp_data;
    logic             res_mismatch;
`endif

    modport master (
        output in_valid, in_data, in_last, res_ready,
`ifdef VECTOR_SEQUENCER_COMPARE_EN
        output exp_data,
        input  res_mismatch,
`endif
        input  in_ready, res_valid, res_data, res_idx
    );

    modport slave (
        input  in_valid, in_data, in_last, res_ready,
`ifdef VECTOR_SEQUENCER_COMPARE_EN
        input  exp_data,
        output res_mismatch,
`endif
        output in_ready, res_valid, res_data, res_idx
    );

endinterface

// File: rtl/vecseq_fifo.sv
// Synchronous FIFO, async active-low reset; extra pointer bit separates full from empty.
module vecseq_fifo #(
    parameter int unsigned W     = 21,
    parameter int unsigned DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_wdata,
    input  logic         i_pop,
    output logic [W-1:0] o_rdata,
    output logic         o_full,
    output logic         o_empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic         w_wr_en;
    logic         w_rd_en;

    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign w_wr_en = i_push && !o_full;
    assign w_rd_en = i_pop && !o_empty;
    assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/vector_sequencer.sv
// Feeds buffered vectors to an external combinational datapath and streams back its outputs.
// Optional output compare and error count under VECTOR_SEQUENCER_COMPARE_EN.
module vector_sequencer
    import vecseq_pkg::*;
#(
    parameter int unsigned IN_W     = DEF_IN_W,
    parameter int unsigned OUT_W    = DEF_OUT_W,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned SETTLE_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SETTLE_W-1:0] cfg_settle,
    vector_sequencer_if.slave   bus,
    output logic [IN_W-1:0]     dut_in,
    input  logic [OUT_W-1:0]    dut_out,
    output logic                busy,
    output logic                done
`ifdef VECTOR_SEQUENCER_COMPARE_EN
    ,
    output logic [IDX_W-1:0]    err_count
`endif
);
    typedef struct packed {
        logic             last;
        logic [IN_W-1:0]  data;
`ifdef VECTOR_SEQUENCER_COMPARE_EN
        logic [OUT_W-1:0] exp;
`endif
    } entry_t;

    entry_t              w_wr_entry;
    entry_t              w_rd_entry;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_hs;
    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_rst_done;
    logic [IN_W-1:0]     r_dut_in;
    logic                r_last;
    logic [SETTLE_W-1:0] r_settle;
    logic [OUT_W-1:0]    r_res_data;
    logic                r_res_valid;
    logic [IDX_W-1:0]    r_idx;
    logic                r_done;

    always_comb begin
        w_wr_entry      = '0;
        w_wr_entry.last = bus.in_last;
        w_wr_entry.data = bus.in_data;
`ifdef VECTOR_SEQUENCER_COMPARE_EN
        w_wr_entry.exp  = bus.exp_data;
`endif
    end

    // in_ready stays low until the first clock after reset release.
    assign bus.in_ready  = r_rst_done && !w_full;
    assign w_push        = bus.in_valid && bus.in_ready;
    assign bus.res_valid = r_res_valid;
    assign bus.res_data  = r_res_data;
    assign bus.res_idx   = r_idx;
    assign dut_in        = r_dut_in;
    assign done          = r_done;
    assign busy          = (r_state != IDLE);

    vecseq_fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata (w_wr_entry),
        .i_pop   (w_pop),
        .o_rdata (w_rd_entry),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (!w_empty) w_state_nxt = APPLY;
            APPLY:   if (r_settle == '0) w_state_nxt = CAPTURE;
            CAPTURE: w_state_nxt = EMIT;
            EMIT:    if (bus.res_ready) w_state_nxt = (!r_last && !w_empty) ? APPLY : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_hs  = (r_state == EMIT) && bus.res_ready;
        w_pop = 1'b0;
        case (r_state)
            IDLE:    w_pop = !w_empty;
            EMIT:    w_pop = w_hs && !r_last && !w_empty;
            default: w_pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_done  <= 1'b0;
            r_dut_in    <= '0;
            r_last      <= 1'b0;
            r_settle    <= '0;
            r_res_data  <= '0;
            r_res_valid <= 1'b0;
            r_idx       <= '0;
            r_done      <= 1'b0;
        end else begin
            r_rst_done <= 1'b1;
            r_done     <= w_hs && r_last;
            if (w_pop) begin
                r_dut_in <= w_rd_entry.data;
                r_last   <= w_rd_entry.last;
                r_settle <= cfg_settle;
            end else if (r_state == APPLY && r_settle != '0) begin
                r_settle <= r_settle - 1'b1;
            end
            if (r_state == CAPTURE) begin
                r_res_data  <= dut_out;
                r_res_valid <= 1'b1;
            end else if (w_hs) begin
                r_res_valid <= 1'b0;
            end
            if (w_hs) r_idx <= r_last ? '0 : r_idx + 1'b1;
        end
    end

`ifdef VECTOR_SEQUENCER_COMPARE_EN
    logic [OUT_W-1:0] r_exp;
    logic             r_mismatch;
    logic             r_clr_pend;
    logic [IDX_W-1:0] r_err;

    assign bus.res_mismatch = r_mismatch;
    assign err_count        = r_err;

    // The count survives the done pulse and is cleared by the first pop of the next run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exp      <= '0;
            r_mismatch <= 1'b0;
            r_clr_pend <= 1'b0;
            r_err      <= '0;
        end else begin
            if (w_pop) r_exp <= w_rd_entry.exp;
            if (r_state == CAPTURE) r_mismatch <= (dut_out != r_exp);
            if (w_hs && r_last)  r_clr_pend <= 1'b1;
            else if (w_pop)      r_clr_pend <= 1'b0;
            if (w_pop && r_clr_pend)
                r_err <= '0;
            else if (w_hs && r_mismatch && r_err != '1)
                r_err <= r_err + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_vector_sequencer.sv
// Directed bench for vector_sequencer with a behavioural stand-in for the datapath.
module tb_vector_sequencer;

    logic        clk;
    logic        rst_n;
    logic [3:0]  cfg_settle;
    logic [19:0] dut_in;
    logic [9:0]  dut_out;
    logic        busy;
    logic        done;
`ifdef VECTOR_SEQUENCER_COMPARE_EN
    logic [15:0] err_count;
`endif

    int unsigned n_cmp;
    int unsigned n_err;

    vector_sequencer_if #(.IN_W(20), .OUT_W(10)) bus ();

    vector_sequencer #(
        .IN_W     (20),
        .OUT_W    (10),
        .DEPTH    (8),
        .SETTLE_W (4)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_settle (cfg_settle),
        .bus        (bus),
        .dut_in     (dut_in),
        .dut_out    (dut_out),
        .busy       (busy),
        .done       (done)
`ifdef VECTOR_SEQUENCER_COMPARE_EN
        ,
        .err_count  (err_count)
`endif
    );

    // Datapath stand-in: 0x210 plus six per set input bit.
    function automatic logic [9:0] dp_model(input logic [19:0] x);
        int unsigned c;
        c = 0;
        for (int i = 0; i < 20; i++) c += 32'(x[i]);
        return 10'(32'h210 + 6 * c);
    endfunction

    assign dut_out = dp_model(dut_in);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_vec(input logic [19:0] d, input logic l, input logic [9:0] e);
        int unsigned n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
`ifdef VECTOR_SEQUENCER_COMPARE_EN
        bus.exp_data = e;
`else
        if (e != 10'h0) bus.in_last = l;
`endif
        while (!bus.in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("push_ready_tmo", 32'(n < 100), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_res(output int unsigned cyc);
        @(posedge clk); #1;
        cyc = 1;
        while (!bus.res_valid && cyc < 64) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("res_valid_tmo", 32'(bus.res_valid), 32'd1);
    endtask

    task automatic handshake();
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
    endtask

    initial begin
        int unsigned cyc;
        int unsigned seen;
        logic [19:0] vec;
        logic [19:0] q [$];

        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        cfg_settle = 4'd0;
        bus.in_valid = 1'b1;
        bus.in_data = 20'h0;
        bus.in_last = 1'b0;
        bus.res_ready = 1'b0;
`ifdef VECTOR_SEQUENCER_COMPARE_EN
        bus.exp_data = 10'h0;
`endif

        // Reset state
        @(posedge clk); #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_dut_in", 32'(dut_in), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Single vector, settle 0
        push_vec(20'h00000, 1'b1, 10'h0);
        wait_res(cyc);
        chk("s0_latency", cyc, 32'd3);
        chk("s0_data", 32'(bus.res_data), 32'h210);
        chk("s0_idx", 32'(bus.res_idx), 32'd0);
        chk("s0_dut_in", 32'(dut_in), 32'h00000);
        handshake();
        chk("s0_done", 32'(done), 32'd1);
        chk("s0_valid_drop", 32'(bus.res_valid), 32'd0);
        @(posedge clk); #1;
        chk("s0_done_pulse", 32'(done), 32'd0);
        chk("s0_idle", 32'(busy), 32'd0);

        // Single vector, settle 3
        cfg_settle = 4'd3;
        push_vec(20'h80020, 1'b1, 10'h0);
        wait_res(cyc);
        chk("s3_latency", cyc, 32'd6);
        chk("s3_data", 32'(bus.res_data), 32'h21C);
        chk("s3_idx", 32'(bus.res_idx), 32'd0);
        handshake();
        chk("s3_done", 32'(done), 32'd1);

        // Back-pressure: nine vectors fill datapath plus FIFO
        cfg_settle = 4'd0;
        for (int k = 0; k < 9; k++) begin
            vec = 20'((32'd1 << k) - 1);
            push_vec(vec, 1'(k == 8), 10'h0);
        end
        chk("bp_full", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b1;
        bus.in_data = 20'hFFFFF;
        bus.in_last = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp_stall_data", 32'(bus.res_data), 32'(dp_model(20'h0)));
            chk("bp_stall_valid", 32'(bus.res_valid), 32'd1);
        end
        chk("bp_stall_ready", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b0;
        bus.res_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            if (k > 0) begin
                wait_res(cyc);
                chk("bp_gap", cyc, 32'd3);
            end
            vec = 20'((32'd1 << k) - 1);
            chk("bp_data", 32'(bus.res_data), 32'(dp_model(vec)));
            chk("bp_idx", 32'(bus.res_idx), 32'(k));
        end
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        chk("bp_done", 32'(done), 32'd1);
        chk("bp_idx_clear", 32'(bus.res_idx), 32'd0);
        @(posedge clk); #1;
        chk("bp_no_extra", 32'(bus.res_valid), 32'd0);

        // Simultaneous push/pop at full
        for (int k = 9; k < 18; k++) begin
            vec = 20'((32'd1 << k) - 1);
            q.push_back(vec);
            push_vec(vec, 1'b0, 10'h0);
        end
        q.push_back(20'h3FFFF);
        chk("pp_full", 32'(bus.in_ready), 32'd0);
        chk("pp_w0", 32'(bus.res_data), 32'(dp_model(q[0])));
        bus.in_valid = 1'b1;
        bus.in_data = 20'h3FFFF;
        bus.in_last = 1'b0;
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        chk("pp_ready_after_pop", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("pp_full_again", 32'(bus.in_ready), 32'd0);
        bus.res_ready = 1'b1;
        for (int k = 1; k < 10; k++) begin
            wait_res(cyc);
            chk("pp_data", 32'(bus.res_data), 32'(dp_model(q[k])));
            chk("pp_idx", 32'(bus.res_idx), 32'(k));
        end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.res_valid) seen++;
        end
        bus.res_ready = 1'b0;
        chk("pp_no_dup", seen, 32'd0);

        // Reset mid-EMIT
        push_vec(20'h00F0F, 1'b0, 10'h0);
        push_vec(20'h00003, 1'b0, 10'h0);
        wait_res(cyc);
        chk("mr_idx_before", 32'(bus.res_idx), 32'd10);
        chk("mr_data_before", 32'(bus.res_data), 32'(dp_model(20'h00F0F)));
        rst_n = 1'b0;
        #1;
        chk("mr_valid", 32'(bus.res_valid), 32'd0);
        chk("mr_in_ready", 32'(bus.in_ready), 32'd0);
        chk("mr_dut_in", 32'(dut_in), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("mr_in_ready_rel", 32'(bus.in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus.res_valid || busy) seen++;
        end
        chk("mr_flushed", seen, 32'd0);
        push_vec(20'h12345, 1'b1, 10'h0);
        wait_res(cyc);
        chk("mr_idx_restart", 32'(bus.res_idx), 32'd0);
        chk("mr_data_after", 32'(bus.res_data), 32'(dp_model(20'h12345)));
        handshake();
        chk("mr_done", 32'(done), 32'd1);

`ifdef VECTOR_SEQUENCER_COMPARE_EN
        // Compare feature
        push_vec(20'h00000, 1'b0, 10'h210);
        push_vec(20'h80020, 1'b1, 10'h000);
        wait_res(cyc);
        chk("cmp_match", 32'(bus.res_mismatch), 32'd0);
        chk("cmp_err_clear", 32'(err_count), 32'd0);
        handshake();
        wait_res(cyc);
        chk("cmp_mismatch", 32'(bus.res_mismatch), 32'd1);
        handshake();
        chk("cmp_done", 32'(done), 32'd1);
        chk("cmp_err_count", 32'(err_count), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
